// File: rtl/diffusion_pkg.sv
// Shared types and defaults for the diffusion scheduler and its round-robin arbiter.
package diffusion_pkg;

  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_STEPS  = 7;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    RUN,
    ADVANCE,
    DONE
  } state_e;

  // Pointer width that stays legal for a single engine.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/diffusion_scheduler_rr_arbiter.sv
// Round-robin arbiter with grant lock for the shared score-table port.
module rr_arbiter
  import diffusion_pkg::*;
#(
  parameter int NUM_PE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_PE-1:0] req,
  output logic [NUM_PE-1:0] grant
);

  localparam int PW = ptr_width(NUM_PE);

  logic [NUM_PE-1:0] grant_q, grant_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     holder, next_ptr, base;
  logic              holding, found;

  always_comb begin
    holder = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (grant_q[i]) holder = PW'(i);
    end
    next_ptr = (int'(holder) == NUM_PE - 1) ? '0 : holder + PW'(1);
  end

  assign holding = |(grant_q & req);

  // A released holder hands off on the same edge that clears it, so only one dead cycle is seen.
  always_comb begin
    grant_d  = '0;
    rr_ptr_d = rr_ptr_q;
    base     = rr_ptr_q;
    found    = 1'b0;
    if (en) begin
      if (holding) begin
        grant_d = grant_q;
      end else begin
        if (|grant_q) begin
          rr_ptr_d = next_ptr;
          base     = next_ptr;
        end
        for (int k = 0; k < NUM_PE; k++) begin
          if (!found && req[(int'(base) + k) % NUM_PE]) begin
            grant_d[(int'(base) + k) % NUM_PE] = 1'b1;
            found = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Masking by req releases the port in the very cycle the holder lets go.
  assign grant = grant_q & req & {NUM_PE{en}};

endmodule

// File: rtl/diffusion_scheduler.sv
// Step sequencer and score-BRAM port sharer for the diffusion engine array.
// Define DIFFUSION_SCHED_PERF_EN to add the step_cycles / conflict_cycles counters.
module diffusion_scheduler
  import diffusion_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_STEPS  = DEF_MAX_STEPS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_PE-1:0]            pe_req,
  input  logic [NUM_PE*ADDR_WIDTH-1:0] pe_addr,
  input  logic [NUM_PE-1:0]            pe_we,
  input  logic [NUM_PE*DATA_WIDTH-1:0] pe_wdata,
  input  logic [NUM_PE-1:0]            pe_finished,
  input  logic [DATA_WIDTH-1:0]        bram_rdata,
  output logic [DATA_WIDTH-1:0]        pe_rdata,
  output logic [ADDR_WIDTH-1:0]        bram_addr,
  output logic                         bram_we,
  output logic [DATA_WIDTH-1:0]        bram_wdata,
  output logic [NUM_PE-1:0]            conflict,
  output logic                         rdy,
  output logic [DATA_WIDTH-1:0]        l_step,
`ifdef DIFFUSION_SCHED_PERF_EN
  output logic [31:0]                  step_cycles,
  output logic [31:0]                  conflict_cycles,
`endif
  output logic                         finished_all,
  output logic                         done
);

  state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0] l_step_q, l_step_d;
  logic                rdy_q, rdy_d, fin_all_q, fin_all_d, done_q, done_d;
  logic [NUM_PE-1:0]   sticky_q, sticky_d, fin_prev_q;
  logic [NUM_PE-1:0]   grant;
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PE];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PE];

  rr_arbiter #(.NUM_PE(NUM_PE)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == RUN),
    .req   (pe_req),
    .grant (grant)
  );

  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_unpack
      assign addr_arr[gi]  = pe_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = pe_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Grant is one-hot or zero, so an OR-mux is sufficient and yields zeros when idle.
  always_comb begin
    bram_addr  = '0;
    bram_wdata = '0;
    bram_we    = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (grant[i]) begin
        bram_addr  = bram_addr | addr_arr[i];
        bram_wdata = bram_wdata | wdata_arr[i];
        bram_we    = bram_we | pe_we[i];
      end
    end
  end

  assign conflict = pe_req & ~grant;
  assign pe_rdata = bram_rdata;

  always_comb begin
    state_d  = state_q;
    l_step_d = l_step_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE:    if (start) state_d = KICK;
      KICK: begin
        sticky_d = '0;
        state_d  = RUN;
      end
      RUN: begin
        // Only a fresh rising edge counts; a level carried over from the last step does not.
        sticky_d = sticky_q | (pe_finished & ~fin_prev_q);
        if (&sticky_q) state_d = ADVANCE;
      end
      ADVANCE: begin
        l_step_d = l_step_q + DATA_WIDTH'(1);
        state_d  = (l_step_d == DATA_WIDTH'(MAX_STEPS)) ? DONE : KICK;
      end
      DONE: begin
        if (start) begin
          l_step_d = '0;
          state_d  = KICK;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d     = (state_d == KICK) || (state_d == RUN);
    fin_all_d = (state_d == KICK);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      l_step_q   <= '0;
      rdy_q      <= 1'b0;
      fin_all_q  <= 1'b0;
      done_q     <= 1'b0;
      sticky_q   <= '0;
      fin_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      l_step_q   <= l_step_d;
      rdy_q      <= rdy_d;
      fin_all_q  <= fin_all_d;
      done_q     <= done_d;
      sticky_q   <= sticky_d;
      fin_prev_q <= pe_finished;
    end
  end

  assign rdy          = rdy_q;
  assign l_step       = l_step_q;
  assign finished_all = fin_all_q;
  assign done         = done_q;

`ifdef DIFFUSION_SCHED_PERF_EN
  logic [31:0] run_cnt_q, run_cnt_d, step_cyc_q, step_cyc_d, conf_cnt_q, conf_cnt_d;

  always_comb begin
    run_cnt_d  = run_cnt_q;
    step_cyc_d = step_cyc_q;
    conf_cnt_d = conf_cnt_q;
    if (state_q == KICK) run_cnt_d = '0;
    if (state_q == RUN) run_cnt_d = run_cnt_q + 32'd1;
    if (state_q == ADVANCE) step_cyc_d = run_cnt_q;
    if (start && (state_q == IDLE || state_q == DONE)) begin
      conf_cnt_d = '0;
    end else if (|conflict && conf_cnt_q != '1) begin
      conf_cnt_d = conf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cnt_q  <= '0;
      step_cyc_q <= '0;
      conf_cnt_q <= '0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      step_cyc_q <= step_cyc_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign step_cycles     = step_cyc_q;
  assign conflict_cycles = conf_cnt_q;
`endif

endmodule

// File: tb/tb_diffusion_scheduler.sv
// Directed-vector bench for diffusion_scheduler (4 engines, 7 steps).
// Perf counters are exercised when DIFFUSION_SCHED_PERF_EN is defined.
module tb_diffusion_scheduler;

  localparam int NPE = 4;
  localparam int AW  = 13;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rst_n, start;
  logic [NPE-1:0]    pe_req, pe_we, pe_finished;
  logic [NPE*AW-1:0] pe_addr;
  logic [NPE*DW-1:0] pe_wdata;
  logic [DW-1:0]     bram_rdata, pe_rdata, bram_wdata, l_step;
  logic [AW-1:0]     bram_addr;
  logic              bram_we, rdy, finished_all, done;
  logic [NPE-1:0]    conflict;
`ifdef DIFFUSION_SCHED_PERF_EN
  logic [31:0]       step_cycles, conflict_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  diffusion_scheduler #(.NUM_PE(NPE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STEPS(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pe_req       (pe_req),
    .pe_addr      (pe_addr),
    .pe_we        (pe_we),
    .pe_wdata     (pe_wdata),
    .pe_finished  (pe_finished),
    .bram_rdata   (bram_rdata),
    .pe_rdata     (pe_rdata),
    .bram_addr    (bram_addr),
    .bram_we      (bram_we),
    .bram_wdata   (bram_wdata),
    .conflict     (conflict),
    .rdy          (rdy),
    .l_step       (l_step),
`ifdef DIFFUSION_SCHED_PERF_EN
    .step_cycles     (step_cycles),
    .conflict_cycles (conflict_cycles),
`endif
    .finished_all (finished_all),
    .done         (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; pe_req = '0; pe_we = '0; pe_finished = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_kick(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      step();
      if (finished_all) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b expected 0", rdy); end
    vectors++; if (finished_all !== 1'b0) begin miscompares++; $display("FAIL reset_finished_all: got %b expected 0", finished_all); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (l_step !== 32'd0) begin miscompares++; $display("FAIL reset_l_step: got %0d expected 0", l_step); end
    vectors++; if (bram_we !== 1'b0 || bram_addr !== '0) begin miscompares++; $display("FAIL reset_bram: we=%b addr=%h expected 0/0", bram_we, bram_addr); end
    vectors++; if (pe_rdata !== 32'hCAFE0001) begin miscompares++; $display("FAIL rdata_broadcast: got %h expected cafe0001", pe_rdata); end
    $display("reset: l_step=%0d rdy=%b done=%b", l_step, rdy, done);
  endtask

  task automatic test_start();
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++; if (finished_all !== 1'b1 || rdy !== 1'b1) begin miscompares++; $display("FAIL start_kick: finished_all=%b rdy=%b expected 1/1", finished_all, rdy); end
    step();
    vectors++; if (finished_all !== 1'b0 || rdy !== 1'b1) begin miscompares++; $display("FAIL start_run: finished_all=%b rdy=%b expected 0/1", finished_all, rdy); end
    $display("start: entered RUN at l_step=%0d", l_step);
  endtask

  task automatic test_round_robin();
    pe_req = 4'b1010; #1;
    vectors++; if (conflict !== 4'b1010) begin miscompares++; $display("FAIL rr_pre_grant_conflict: got %b expected 1010", conflict); end
    step();
    vectors++; if (conflict !== 4'b1000 || bram_addr !== 13'h11) begin miscompares++; $display("FAIL rr_grant_pe1: conflict=%b addr=%h expected 1000/011", conflict, bram_addr); end
    pe_req = 4'b1001; #1;
    vectors++; if (conflict !== 4'b1001 || bram_addr !== 13'h0) begin miscompares++; $display("FAIL rr_dead_cycle: conflict=%b addr=%h expected 1001/000", conflict, bram_addr); end
    step();
    vectors++; if (conflict !== 4'b0001 || bram_addr !== 13'h33) begin miscompares++; $display("FAIL rr_grant_pe3: conflict=%b addr=%h expected 0001/033", conflict, bram_addr); end
    pe_req = 4'b0001;
    step();
    vectors++; if (conflict !== 4'b0000 || bram_addr !== 13'h100) begin miscompares++; $display("FAIL rr_grant_pe0: conflict=%b addr=%h expected 0000/100", conflict, bram_addr); end
    pe_req = 4'b0000;
    step();
    $display("round_robin: PE1 -> PE3 -> PE0 sequence applied");
  endtask

  task automatic test_grant_lock();
    pe_we = 4'b0100;
    pe_req = 4'b0101;
    step();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bram_addr !== 13'h0A || bram_we !== 1'b1 || bram_wdata !== 32'h55 || conflict !== 4'b0001) begin
        miscompares++;
        $display("FAIL lock_cycle%0d: addr=%h we=%b wdata=%h conflict=%b expected 00a/1/55/0001", i, bram_addr, bram_we, bram_wdata, conflict);
      end
      if (i < 4) step();
    end
    pe_req = 4'b0001; #1;
    vectors++; if (bram_we !== 1'b0 || conflict !== 4'b0001) begin miscompares++; $display("FAIL lock_release: we=%b conflict=%b expected 0/0001", bram_we, conflict); end
    step();
    vectors++; if (bram_we !== 1'b0 || conflict !== 4'b0000 || bram_addr !== 13'h100) begin miscompares++; $display("FAIL lock_handoff_pe0: we=%b conflict=%b addr=%h expected 0/0000/100", bram_we, conflict, bram_addr); end
    pe_req = '0; pe_we = '0;
    step();
    $display("grant_lock: PE2 held 5 cycles, PE0 handed off");
  endtask

  task automatic test_finish_edge();
    int pulses;
    bit seen;
    pe_finished = 4'b1111;
    step();
    step();
    vectors++; if (rdy !== 1'b0 || l_step !== 32'd0) begin miscompares++; $display("FAIL advance_state: rdy=%b l_step=%0d expected 0/0", rdy, l_step); end
    step();
    vectors++; if (finished_all !== 1'b1 || l_step !== 32'd1) begin miscompares++; $display("FAIL kick_step1: finished_all=%b l_step=%0d expected 1/1", finished_all, l_step); end
    pulses = 0;
    for (int c = 0; c < 10; c++) begin step(); if (finished_all) pulses++; end
    vectors++; if (pulses !== 0 || rdy !== 1'b1) begin miscompares++; $display("FAIL held_level_ignored: pulses=%0d rdy=%b expected 0/1", pulses, rdy); end
    pe_finished = 4'b1000;
    step();
    pe_finished = 4'b1111;
    for (int c = 0; c < 6; c++) begin step(); if (finished_all) pulses++; end
    vectors++; if (pulses !== 0 || l_step !== 32'd1) begin miscompares++; $display("FAIL partial_reraise: pulses=%0d l_step=%0d expected 0/1", pulses, l_step); end
    pe_finished = 4'b0111;
    step();
    pe_finished = 4'b1111;
    wait_kick(10, seen);
    vectors++; if (!seen || l_step !== 32'd2) begin miscompares++; $display("FAIL full_reraise: kick_seen=%b l_step=%0d expected 1/2", seen, l_step); end
    $display("finish_edge: step advanced to %0d after all engines re-raised", l_step);
  endtask

  task automatic test_full_run();
    int pulses, cnt;
    do_reset();
    pulses = 0; cnt = 0;
    start = 1'b1;
    for (int c = 0; c < 2000 && !done; c++) begin
      step();
      start = 1'b0;
      if (finished_all) begin
        pulses++; pe_finished = '0; cnt = 10;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) pe_finished = 4'b1111;
      end
    end
    vectors++; if (done !== 1'b1 || pulses !== 7 || l_step !== 32'd7 || rdy !== 1'b0) begin miscompares++; $display("FAIL full_run: done=%b pulses=%0d l_step=%0d rdy=%b expected 1/7/7/0", done, pulses, l_step, rdy); end
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++; if (finished_all !== 1'b1 || l_step !== 32'd0 || done !== 1'b0) begin miscompares++; $display("FAIL restart: finished_all=%b l_step=%0d done=%b expected 1/0/0", finished_all, l_step, done); end
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++; if (finished_all !== 1'b0 || l_step !== 32'd0 || rdy !== 1'b1) begin miscompares++; $display("FAIL start_in_run: finished_all=%b l_step=%0d rdy=%b expected 0/0/1", finished_all, l_step, rdy); end
    $display("full_run: %0d steps, restarted at l_step=%0d", pulses, l_step);
  endtask

`ifdef DIFFUSION_SCHED_PERF_EN
  task automatic test_perf();
    bit seen;
    pe_finished = '0;
    step();
    pe_finished = 4'b1111;
    wait_kick(20, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL perf_sync_kick: kick_seen=%b expected 1", seen); end
    pe_finished = '0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) pe_req = 4'b0011;
      if (c == 4) pe_req = 4'b0000;
      if (c == 11) pe_finished = 4'b1111;
    end
    step();
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL perf_advance: rdy=%b expected 0", rdy); end
    step();
    vectors++; if (finished_all !== 1'b1 || step_cycles !== 32'd12 || conflict_cycles !== 32'd3) begin miscompares++; $display("FAIL perf_counters: kick=%b step_cycles=%0d conflict_cycles=%0d expected 1/12/3", finished_all, step_cycles, conflict_cycles); end
    $display("perf: step_cycles=%0d conflict_cycles=%0d", step_cycles, conflict_cycles);
  endtask
`endif

  task automatic test_reset_mid_run();
    int cnt;
    bit reached;
    pe_finished = '0; cnt = 3; reached = 1'b0;
    for (int c = 0; c < 500 && !reached; c++) begin
      step();
      if (finished_all) begin
        pe_finished = '0; cnt = 3;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) pe_finished = 4'b1111;
      end
      if (l_step == 32'd3 && rdy && !finished_all) reached = 1'b1;
    end
    vectors++; if (!reached) begin miscompares++; $display("FAIL midrun_reach_step3: reached=%b l_step=%0d expected 1/3", reached, l_step); end
    pe_finished = '0;
    pe_req = 4'b0010; pe_we = 4'b0010;
    step();
    step();
    vectors++; if (bram_we !== 1'b1 || bram_addr !== 13'h11) begin miscompares++; $display("FAIL midrun_write_active: we=%b addr=%h expected 1/011", bram_we, bram_addr); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++; if (rdy !== 1'b0 || l_step !== 32'd0 || bram_we !== 1'b0 || conflict !== 4'b0010) begin miscompares++; $display("FAIL midrun_reset: rdy=%b l_step=%0d we=%b conflict=%b expected 0/0/0/0010", rdy, l_step, bram_we, conflict); end
    step();
    vectors++; if (rdy !== 1'b0 || bram_we !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midrun_idle_hold: rdy=%b we=%b done=%b expected 0/0/0", rdy, bram_we, done); end
    pe_req = '0; pe_we = '0;
    $display("reset_mid_run: aborted at step 3, back to IDLE");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pe_req = '0; pe_we = '0; pe_finished = '0;
    bram_rdata = 32'hCAFE0001;
    pe_addr  = {13'h33, 13'h0A, 13'h11, 13'h100};
    pe_wdata = {32'h3333, 32'h55, 32'h1111, 32'h0};
    test_reset();
    test_start();
    test_round_robin();
    test_grant_lock();
    test_finish_edge();
    test_full_run();
`ifdef DIFFUSION_SCHED_PERF_EN
    test_perf();
`endif
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
